// File: rtl/pga_pkg.sv
// Shared types and constants for the PGA serial write interface.
package pga_pkg;

  localparam int PGA_CODE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } pga_state_t;

endpackage

// File: rtl/pga_if.sv
// Request/serial bundle between gain control and the PGA write port.
interface pga_if
  import pga_pkg::*;
#(
  parameter int CODE_W = PGA_CODE_W
);

  logic [CODE_W-1:0] code_i;
  logic              set_i;
  logic              ready_o;
  logic              cs_n;
  logic              miso;

  modport master (
    output code_i,
    output set_i,
    input  ready_o,
    input  cs_n,
    input  miso
  );

  modport slave (
    input  code_i,
    input  set_i,
    output ready_o,
    output cs_n,
    output miso
  );

endinterface

// File: rtl/pga_interface.sv
// Serial write-only PGA gain interface clocked directly by sck.
// Control runs on rising edges, data is launched on falling edges.
module pga_interface
  import pga_pkg::*;
#(
  parameter int CODE_W  = PGA_CODE_W,
  parameter int CS_HOLD = 1
) (
  input  logic sck,
  input  logic rst,
  pga_if.slave bus
);

  localparam int CW = $clog2(CODE_W + 1);
  localparam int HW = $clog2(CS_HOLD + 1);

  localparam logic [CW-1:0] LAST_BIT  = CW'(CODE_W);
  localparam logic [HW-1:0] LAST_HOLD = HW'(CS_HOLD - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_HOLD  = HOLD;

  logic [1:0]        state;
  logic [CW-1:0]     bit_cnt;
  logic [HW-1:0]     hold_cnt;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] sreg;
  logic              miso_q;
  logic              launch;

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      hold_cnt <= '0;
      code_q   <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (bus.set_i) begin
            code_q  <= bus.code_i;
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end
        end
        (state == S_SHIFT): begin
          if (bit_cnt == LAST_BIT) begin
            hold_cnt <= '0;
            state    <= S_HOLD;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        (state == S_HOLD): begin
          if (hold_cnt == LAST_HOLD) begin
            state <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bit k is launched half a cycle before sampling edge k+1.
  assign launch = (state == S_SHIFT) && (bit_cnt != LAST_BIT);

  always_ff @(negedge sck or posedge rst) begin
    if (rst) begin
      sreg   <= '0;
      miso_q <= 1'b0;
    end else if (launch) begin
      if (bit_cnt == '0) begin
        {miso_q, sreg} <= {code_q, 1'b0};
      end else begin
        {miso_q, sreg} <= {sreg, 1'b0};
      end
    end else begin
      sreg   <= '0;
      miso_q <= 1'b0;
    end
  end

  assign bus.ready_o = (state == S_IDLE);
  assign bus.cs_n    = (state != S_SHIFT);
  assign bus.miso    = miso_q;

endmodule

// File: tb/tb_pga_interface.sv
// Randomized self-checking bench for pga_interface.
module tb_pga_interface;
  import pga_pkg::*;

  localparam int W = PGA_CODE_W;
  localparam int H = 1;

  logic sck = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  pga_if #(.CODE_W(W)) bus ();

  pga_interface #(
    .CODE_W (W),
    .CS_HOLD(H)
  ) dut (
    .sck(sck),
    .rst(rst),
    .bus(bus)
  );

  always #5 sck = ~sck;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sck);
    #2;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("ready_timeout", 32'(bus.ready_o), 1);
  endtask

  task automatic idle_gap(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.cs_n !== 1'b1 || bus.miso !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);
  endtask

  // Model: bits go out MSB first on sampling edges R1..RW,
  // cs_n rises at R(W+1), ready at R(W+1+H).
  task automatic frame(input logic [W-1:0] code,
                       input bit hold,
                       input logic [W-1:0] next,
                       input bit poke,
                       input bit scramble);
    logic [W-1:0] got;
    int poke_at;
    int cs_bad;
    got = '0;
    cs_bad = 0;
    poke_at = int'($urandom_range(1, W - 1));
    wait_ready();
    bus.code_i = code;
    bus.set_i  = 1'b1;
    tick();
    check("accept_cs", 32'(bus.cs_n), 0);
    check("accept_rdy", 32'(bus.ready_o), 0);
    if (hold) bus.code_i = next;
    else bus.set_i = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (scramble) bus.code_i = W'($urandom);
      if (poke && k == poke_at) begin
        bus.set_i  = 1'b1;
        bus.code_i = '0;
      end else if (poke && k == poke_at + 1) begin
        bus.set_i = 1'b0;
      end
      tick();
      got[W-k] = bus.miso;
      if (bus.cs_n !== 1'b0 || bus.ready_o !== 1'b0) cs_bad++;
    end
    if (poke) bus.set_i = 1'b0;
    check("cs_low", cs_bad, 0);
    tick();
    check("end_cs", 32'(bus.cs_n), 1);
    check("end_miso", 32'(bus.miso), 0);
    check("end_rdy", 32'(bus.ready_o), 0);
    for (int h = 1; h < H; h++) begin
      tick();
      check("hold_rdy", 32'(bus.ready_o), 0);
    end
    tick();
    check("ready_back", 32'(bus.ready_o), 1);
    check("ready_cs", 32'(bus.cs_n), 1);
    check("data", 32'(got), 32'(code));
    if (poke) begin
      tick();
      check("no_refire", 32'(bus.cs_n), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.code_i = '0;
    bus.set_i  = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_rdy", 32'(bus.ready_o), 1);
    check("rst_cs", 32'(bus.cs_n), 1);
    check("rst_miso", 32'(bus.miso), 0);
    tick();
    tick();
    rst = 1'b0;
    idle_gap(2);

    frame(8'h8F, 1'b0, 8'h00, 1'b0, 1'b0);
    frame(8'hA5, 1'b0, 8'h00, 1'b1, 1'b0);
    frame(8'h3C, 1'b0, 8'h00, 1'b0, 1'b1);
    frame(8'hFF, 1'b1, 8'h01, 1'b0, 1'b0);
    frame(8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_gap(2);

    wait_ready();
    bus.code_i = 8'h96;
    bus.set_i  = 1'b1;
    tick();
    bus.set_i = 1'b0;
    repeat (4) tick();
    #1 rst = 1'b1;
    #1;
    check("midrst_cs", 32'(bus.cs_n), 1);
    check("midrst_rdy", 32'(bus.ready_o), 1);
    check("midrst_miso", 32'(bus.miso), 0);
    tick();
    rst = 1'b0;
    idle_gap(1);
    frame(8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      idle_gap(int'($urandom_range(0, 3)));
      frame(W'($urandom), 1'b0, 8'h00,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
